cdb_arbiter: RTL and testbench

//  Shares the single Common Data Bus among the four execution units: Div, Mult, Int, Lsb.
//  Div and Mult own CDB slots that the issue unit pre-reserves, so they are granted the

---
 rtl/cdb_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: Div/Mult granted on arrival, Int/Lsb buffered
// in FIFOs and drained round-robin into free slots; CDB outputs registered.
//
// cdb_fifo ports:
//   clk, reset          clock, async active-high reset
//   push, pop           write at wr_ptr / advance rd_ptr
//   din_tag, din_data   entry written on push
//   head_tag, head_data oldest entry
//   not_empty, ready    count != 0 / count != DEPTH
//
// cdb_arbiter ports:
//   clk, reset                    clock, async active-high reset
//   div_valid/tag/data            Div result, always taken
//   mult_valid/tag/data           Mult result, taken unless Div is valid
//   int_valid/tag/data, int_ready Int result offer and FIFO-not-full
//   lsb_valid/tag/data, lsb_ready Lsb result offer and FIFO-not-full
//   cdb_valid/tag/data/src        registered broadcast (src 0=Int 1=Lsb 2=Mult 3=Div)
//   err_collision                 sticky Div+Mult same-cycle flag

module cdb_fifo #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [TAG_W-1:0]  din_tag,
    input  logic [DATA_W-1:0] din_data,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_data,
    output logic              not_empty,
    output logic              ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    assign head_tag  = tag_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign not_empty = (count != '0);
    assign ready     = (count != CW'(DEPTH));

    // Storage needs no reset; only occupancy state is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= din_tag;
            data_mem[wr_ptr] <= din_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_valid,
    input  logic [TAG_W-1:0]  div_tag,
    input  logic [DATA_W-1:0] div_data,
    input  logic              mult_valid,
    input  logic [TAG_W-1:0]  mult_tag,
    input  logic [DATA_W-1:0] mult_data,
    input  logic              int_valid,
    input  logic [TAG_W-1:0]  int_tag,
    input  logic [DATA_W-1:0] int_data,
    output logic              int_ready,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_data,
    output logic              lsb_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src,
    output logic              err_collision
);
    logic              int_ne, lsb_ne;
    logic              int_pop, lsb_pop;
    logic [TAG_W-1:0]  int_htag, lsb_htag;
    logic [DATA_W-1:0] int_hdata, lsb_hdata;

    logic              lru, lru_nxt;
    logic              gnt;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_src;

    cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_int_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (int_valid && int_ready),
        .pop       (int_pop),
        .din_tag   (int_tag),
        .din_data  (int_data),
        .head_tag  (int_htag),
        .head_data (int_hdata),
        .not_empty (int_ne),
        .ready     (int_ready)
    );

    cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lsb_valid && lsb_ready),
        .pop       (lsb_pop),
        .din_tag   (lsb_tag),
        .din_data  (lsb_data),
        .head_tag  (lsb_htag),
        .head_data (lsb_hdata),
        .not_empty (lsb_ne),
        .ready     (lsb_ready)
    );

    // Fixed priority Div > Mult > FIFO heads. Between two ready heads,
    // lru picks (0=Int); a lone head grant still steers lru to the other unit.
    always_comb begin
        gnt      = 1'b0;
        int_pop  = 1'b0;
        lsb_pop  = 1'b0;
        lru_nxt  = lru;
        sel_tag  = '0;
        sel_data = '0;
        sel_src  = 2'd0;
        priority case (1'b1)
            div_valid: begin
                gnt      = 1'b1;
                sel_tag  = div_tag;
                sel_data = div_data;
                sel_src  = 2'd3;
            end
            mult_valid: begin
                gnt      = 1'b1;
                sel_tag  = mult_tag;
                sel_data = mult_data;
                sel_src  = 2'd2;
            end
            (int_ne && lsb_ne): begin
                gnt     = 1'b1;
                lru_nxt = ~lru;
                if (!lru) begin
                    int_pop  = 1'b1;
                    sel_tag  = int_htag;
                    sel_data = int_hdata;
                    sel_src  = 2'd0;
                end else begin
                    lsb_pop  = 1'b1;
                    sel_tag  = lsb_htag;
                    sel_data = lsb_hdata;
                    sel_src  = 2'd1;
                end
            end
            int_ne: begin
                gnt      = 1'b1;
                int_pop  = 1'b1;
                lru_nxt  = 1'b1;
                sel_tag  = int_htag;
                sel_data = int_hdata;
                sel_src  = 2'd0;
            end
            lsb_ne: begin
                gnt      = 1'b1;
                lsb_pop  = 1'b1;
                lru_nxt  = 1'b0;
                sel_tag  = lsb_htag;
                sel_data = lsb_hdata;
                sel_src  = 2'd1;
            end
            default: gnt = 1'b0;
        endcase
    end

    // Tag/data/src hold through idle cycles; only cdb_valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_data      <= '0;
            cdb_src       <= 2'd0;
            lru           <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            cdb_valid <= gnt;
            lru       <= lru_nxt;
            if (gnt) begin
                cdb_tag  <= sel_tag;
                cdb_data <= sel_data;
                cdb_src  <= sel_src;
            end
            if (div_valid && mult_valid)
                err_collision <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: table-driven cycle vectors plus directed
// sequences for FIFO back-pressure and mid-stream reset.

module tb_cdb_arbiter;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          div_valid, mult_valid, int_valid, lsb_valid;
    logic [TW-1:0] div_tag, mult_tag, int_tag, lsb_tag;
    logic [DW-1:0] div_data, mult_data, int_data, lsb_data;
    logic          int_ready, lsb_ready;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [1:0]    cdb_src;
    logic          err_collision;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(.DATA_W(DW), .TAG_W(TW), .DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .div_valid     (div_valid),
        .div_tag       (div_tag),
        .div_data      (div_data),
        .mult_valid    (mult_valid),
        .mult_tag      (mult_tag),
        .mult_data     (mult_data),
        .int_valid     (int_valid),
        .int_tag       (int_tag),
        .int_data      (int_data),
        .int_ready     (int_ready),
        .lsb_valid     (lsb_valid),
        .lsb_tag       (lsb_tag),
        .lsb_data      (lsb_data),
        .lsb_ready     (lsb_ready),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .cdb_src       (cdb_src),
        .err_collision (err_collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dv;
        logic [TW-1:0] dt;
        logic          mv;
        logic [TW-1:0] mt;
        logic          iv;
        logic [TW-1:0] it;
        logic          lv;
        logic [TW-1:0] lt;
        logic          ev;
        logic [TW-1:0] et;
        logic [1:0]    es;
        logic          ee;
    } vec_t;

    vec_t vecs[$];

    // Data is a function of the tag so tag 5 carries 0xA5.
    function automatic logic [DW-1:0] dof(logic [TW-1:0] t);
        return 32'hA0 | {{(DW-TW){1'b0}}, t};
    endfunction

    function automatic logic [DW-1:0] exp_data(logic [TW-1:0] t);
        return (t == '0) ? '0 : dof(t);
    endfunction

    function automatic vec_t mk(
        logic dv, logic [TW-1:0] dt, logic mv, logic [TW-1:0] mt,
        logic iv, logic [TW-1:0] it, logic lv, logic [TW-1:0] lt,
        logic ev, logic [TW-1:0] et, logic [1:0] es, logic ee);
        vec_t v;
        v.dv = dv; v.dt = dt; v.mv = mv; v.mt = mt;
        v.iv = iv; v.it = it; v.lv = lv; v.lt = lt;
        v.ev = ev; v.et = et; v.es = es; v.ee = ee;
        return v;
    endfunction

    task automatic chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    task automatic drive(logic dv, logic [TW-1:0] dt, logic mv,
                         logic [TW-1:0] mt, logic iv, logic [TW-1:0] it,
                         logic lv, logic [TW-1:0] lt);
        div_valid  = dv; div_tag  = dt; div_data  = dof(dt);
        mult_valid = mv; mult_tag = mt; mult_data = dof(mt);
        int_valid  = iv; int_tag  = it; int_data  = dof(it);
        lsb_valid  = lv; lsb_tag  = lt; lsb_data  = dof(lt);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic chk_cdb(string n, logic v, logic [TW-1:0] t,
                           logic [1:0] s);
        chk({n, ".valid"}, DW'(cdb_valid), DW'(v));
        chk({n, ".tag"}, DW'(cdb_tag), DW'(t));
        chk({n, ".data"}, cdb_data, exp_data(t));
        if (v) chk({n, ".src"}, DW'(cdb_src), DW'(s));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(negedge clk);
        // 1: reset state
        chk("rst.valid", DW'(cdb_valid), 0);
        chk("rst.tag", DW'(cdb_tag), 0);
        chk("rst.data", cdb_data, 0);
        chk("rst.src", DW'(cdb_src), 0);
        chk("rst.err", DW'(err_collision), 0);
        chk("rst.iready", DW'(int_ready), 1);
        chk("rst.lready", DW'(lsb_ready), 1);

        //            dv dt  mv mt  iv it  lv lt  ev et  es ee
        // 2: single Int result, 2-cycle latency, one-cycle pulse
        vecs.push_back(mk(0, 0,  0, 0,  1, 5,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 5,  0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 5,  0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 5,  0, 0));
        // lone Lsb grant steers lru back to Int
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  1, 6,  0, 5,  0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 6,  1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 6,  1, 0));
        // 4: load 2+2 behind Mult, then round-robin 0,1,0,1
        vecs.push_back(mk(0, 0,  1, 20, 1, 11, 1, 12, 1, 20, 2, 0));
        vecs.push_back(mk(0, 0,  1, 21, 1, 13, 1, 14, 1, 21, 2, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 11, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 12, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 13, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 14, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 14, 1, 0));
        // 5: collision, Div wins, Mult tag 9 dropped, sticky error
        vecs.push_back(mk(1, 7,  1, 9,  0, 0,  0, 0,  1, 7,  3, 1));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 7,  3, 1));
        // Div then Mult pre-empt a waiting Int head
        vecs.push_back(mk(1, 30, 0, 0,  1, 15, 0, 0,  1, 30, 3, 1));
        vecs.push_back(mk(0, 0,  1, 31, 0, 0,  0, 0,  1, 31, 2, 1));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  1, 15, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 15, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].dv, vecs[i].dt, vecs[i].mv, vecs[i].mt,
                  vecs[i].iv, vecs[i].it, vecs[i].lv, vecs[i].lt);
            step();
            chk_cdb($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et,
                    vecs[i].es);
            chk($sformatf("vec%0d.err", i), DW'(err_collision),
                DW'(vecs[i].ee));
            chk($sformatf("vec%0d.iready", i), DW'(int_ready), 1);
            chk($sformatf("vec%0d.lready", i), DW'(lsb_ready), 1);
            if (cdb_valid && cdb_tag == 6'd9)
                chk("dropped_mult_tag", DW'(cdb_tag), 0);
        end

        // 3: fill Int FIFO behind Mult, then drain in push order
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 1, 6'(50 + i), 1, 6'(41 + i), 0, 0);
            step();
            chk($sformatf("fill%0d.iready", i), DW'(int_ready),
                DW'(i < D - 1));
            chk_cdb($sformatf("fill%0d", i), 1, 6'(50 + i), 2);
        end
        // offer while full: must not be accepted
        drive(0, 0, 1, 60, 1, 45, 0, 0);
        step();
        chk("full.iready", DW'(int_ready), 0);
        chk_cdb("full", 1, 60, 2);
        idle();
        for (int i = 0; i < D; i++) begin
            step();
            chk_cdb($sformatf("drain%0d", i), 1, 6'(41 + i), 0);
            chk($sformatf("drain%0d.iready", i), DW'(int_ready), 1);
        end
        step();
        chk_cdb("drain_end", 0, 44, 0);

        // 6: async reset with both FIFOs partly full, CDB busy, err set
        do_reset();
        drive(1, 33, 1, 34, 1, 35, 1, 36);
        step();
        drive(0, 0, 1, 37, 1, 38, 1, 39);
        step();
        chk_cdb("pre_rst", 1, 37, 2);
        chk("pre_rst.err", DW'(err_collision), 1);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst.valid", DW'(cdb_valid), 0);
        chk("mid_rst.tag", DW'(cdb_tag), 0);
        chk("mid_rst.data", cdb_data, 0);
        chk("mid_rst.src", DW'(cdb_src), 0);
        chk("mid_rst.err", DW'(err_collision), 0);
        chk("mid_rst.iready", DW'(int_ready), 1);
        chk("mid_rst.lready", DW'(lsb_ready), 1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_cdb($sformatf("post_rst%0d", i), 0, 0, 0);
        end
        // FIFOs still usable after reset, lru restarted at Int
        drive(0, 0, 0, 0, 1, 1, 1, 2);
        step();
        idle();
        step();
        chk_cdb("post_rst_int", 1, 1, 0);
        step();
        chk_cdb("post_rst_lsb", 1, 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
